// File: rtl/timer_pkg.sv
// Shared mode and channel-state encodings for the multi-channel timer.
// Mode 2'b11 has no constant and is decoded as off.
package timer_pkg;

    localparam logic [1:0] MODE_OFF      = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic [1:0] load_state(input logic [1:0] mode);
        logic [1:0] st;
        case (mode)
            MODE_PERIODIC, MODE_ONESHOT: st = ST_RUN;
            MODE_OFF:                    st = ST_IDLE;
            default:                     st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: period register, tick counter, IDLE/RUN/DONE FSM, pulse and sticky irq.
// Expiry is registered; a load always takes priority over a coincident tick.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [1:0]       mode_i,
    input  logic             ack_i,
    output logic             pulse_o,
    output logic             irq_o,
    output logic             busy_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] cont_q, cont_d;
    logic             oneshot_q, oneshot_d;
    logic             pulse_q, pulse_d;
    logic             irq_q, irq_d;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        cont_d    = cont_q;
        oneshot_d = oneshot_q;
        pulse_d   = 1'b0;
        if (load_i) begin
            period_d  = period_i;
            cont_d    = '0;
            oneshot_d = (mode_i == MODE_ONESHOT);
            state_d   = load_state(mode_i);
        end else if (state_q == ST_RUN && tick_i) begin
            if (cont_q == period_q) begin
                pulse_d = 1'b1;
                cont_d  = '0;
                if (oneshot_q) begin
                    state_d = ST_DONE;
                end
            end else begin
                cont_d = cont_q + 1'b1;
            end
        end
        // A fresh expiry beats an acknowledge arriving in the same cycle.
        irq_d = pulse_d | (irq_q & ~ack_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            cont_q    <= '0;
            oneshot_q <= 1'b0;
            pulse_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            cont_q    <= cont_d;
            oneshot_q <= oneshot_d;
            pulse_q   <= pulse_d;
            irq_q     <= irq_d;
        end
    end

    assign pulse_o = pulse_q;
    assign irq_o   = irq_q;
    assign busy_o  = (state_q == ST_RUN);

endmodule

// File: rtl/timer_multi.sv
// NCH independent timer channels driven by one shared prescaler tick.
// Writes decode to a per-channel load strobe; out-of-range channel numbers match nothing.
module timer_multi
    import timer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int PSC_W = 4,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PSC_W-1:0] prescale,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [WIDTH-1:0] wr_period,
    input  logic [1:0]       wr_mode,
    input  logic [NCH-1:0]   irq_ack,
    output logic [NCH-1:0]   pulse,
    output logic [NCH-1:0]   irq,
    output logic [NCH-1:0]   busy
);

    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic             tick;

    // Lowering prescale below the current count lets the counter wrap through all-ones.
    assign tick      = (psc_cnt_q == prescale);
    assign psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic load;
        assign load = wr_en && (wr_ch == CH_W'(k));

        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (reset),
            .tick_i  (tick),
            .load_i  (load),
            .period_i(wr_period),
            .mode_i  (wr_mode),
            .ack_i   (irq_ack[k]),
            .pulse_o (pulse[k]),
            .irq_o   (irq[k]),
            .busy_o  (busy[k])
        );
    end

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboarded bench: a tick-counting reference model predicts pulse/irq/busy every clock.
module tb_timer_multi;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int PSC_W = 4;
    localparam int VW    = 3 * NCH;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [PSC_W-1:0] prescale = '0;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_ch = '0;
    logic [WIDTH-1:0] wr_period = '0;
    logic [1:0]       wr_mode = '0;
    logic [NCH-1:0]   irq_ack = '0;
    logic [NCH-1:0]   pulse, irq, busy;

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;

    logic [VW-1:0] exp_q[$];

    // Reference model state: ticks elapsed since the channel (re)started.
    int psc_m;
    bit run_m[NCH];
    bit one_m[NCH];
    int per_m[NCH];
    int ticks_m[NCH];
    bit irq_m[NCH];

    timer_multi #(.NCH(NCH), .WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .prescale (prescale),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_period(wr_period),
        .wr_mode  (wr_mode),
        .irq_ack  (irq_ack),
        .pulse    (pulse),
        .irq      (irq),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        psc_m = 0;
        for (int k = 0; k < NCH; k++) begin
            run_m[k] = 0; one_m[k] = 0; per_m[k] = 0; ticks_m[k] = 0; irq_m[k] = 0;
        end
    endtask

    initial model_clear();

    always @(posedge clk) begin
        logic [NCH-1:0] p_e, i_e, b_e;
        bit tk;
        p_e = '0; i_e = '0; b_e = '0;
        if (!reset) begin
            model_clear();
        end else begin
            tk = (psc_m == int'(prescale));
            psc_m = tk ? 0 : (psc_m + 1) % (1 << PSC_W);
            for (int k = 0; k < NCH; k++) begin
                bit fired;
                fired = 0;
                if (wr_en && int'(wr_ch) == k) begin
                    per_m[k]   = int'(wr_period);
                    ticks_m[k] = 0;
                    one_m[k]   = (wr_mode == 2'b10);
                    run_m[k]   = (wr_mode == 2'b01) || (wr_mode == 2'b10);
                end else if (run_m[k] && tk) begin
                    ticks_m[k]++;
                    if (ticks_m[k] == per_m[k] + 1) begin
                        fired = 1;
                        ticks_m[k] = 0;
                        if (one_m[k]) run_m[k] = 0;
                    end
                end
                irq_m[k] = fired || (irq_m[k] && !irq_ack[k]);
                p_e[k] = fired;
                i_e[k] = irq_m[k];
                b_e[k] = run_m[k];
            end
        end
        exp_q.push_back({p_e, i_e, b_e});
    end

    // Asynchronous reset between edges: the pending expectation becomes all-zero.
    always @(negedge reset) begin
        model_clear();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            exp_q.push_back('0);
        end
    end

    always @(negedge clk) begin
        logic [VW-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pulse, irq, busy};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t {pulse,irq,busy} got %h expected %h", $time, a, e);
            end
            pulses_seen += $countones(pulse);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int per, input int mode);
        wr_en     = 1'b1;
        wr_ch     = 2'(ch);
        wr_period = WIDTH'(per);
        wr_mode   = 2'(mode);
        @(negedge clk);
        wr_en     = 1'b0;
    endtask

    initial begin
        idle(3);
        reset = 1'b1;
        idle(2);

        prescale = 4'd0;
        wr(0, 3, 1);
        idle(20);

        irq_ack[0] = 1'b1;
        idle(4);
        irq_ack[0] = 1'b0;
        idle(8);
        irq_ack[0] = 1'b1;
        idle(1);
        irq_ack[0] = 1'b0;

        prescale = 4'd2;
        wr(1, 1, 2);
        idle(50);

        idle(2);
        wr(0, 5, 1);
        idle(40);

        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({pulse, irq, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h expected 0", {pulse, irq, busy});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(20);

        prescale = 4'd0;
        for (int k = 0; k < NCH; k++) wr(k, k, 1);
        idle(30);

        for (int c = 0; c < 3000; c++) begin
            wr_en     = ($urandom_range(0, 7) == 0);
            wr_ch     = 2'($urandom_range(0, NCH - 1));
            wr_period = WIDTH'($urandom_range(0, 7));
            wr_mode   = 2'($urandom_range(0, 3));
            irq_ack   = NCH'($urandom) & NCH'($urandom);
            if ($urandom_range(0, 63) == 0) prescale = PSC_W'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) prescale = 4'd0;
            @(negedge clk);
        end
        wr_en   = 1'b0;
        irq_ack = '0;
        idle(3);

        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected <=1", exp_q.size());
        end
        checks++;
        if (pulses_seen == 0) begin
            errors++;
            $display("FAIL activity got 0 pulses expected >0");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
